// File: rtl/bitcnt_unit.sv
// Two-stage cpop/clz/ctz unit: S1 turns the operand into a mask, S2 popcounts it.
// Optional `BITCNT_PERF_EN adds a 32-bit count of output transfers on perf_count.
module bitcnt_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [4:0]            in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [4:0]            out_tag,
  output logic                  busy
`ifdef BITCNT_PERF_EN
  ,
  output logic [31:0]           perf_count
`endif
);

  localparam int LOGW = $clog2(DATA_WIDTH);
  localparam int CW   = LOGW + 1;

  localparam logic [1:0] OP_CPOP = 2'b00;
  localparam logic [1:0] OP_CLZ  = 2'b01;
  localparam logic [1:0] OP_CTZ  = 2'b10;

  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_s1_mask;
  logic [4:0]            r_s1_tag;
  logic                  r_s2_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [4:0]            r_out_tag;

  logic                  w_adv;
  logic                  w_s2_load;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [CW-1:0]         w_count;

  // clz: the set bits of m are exactly the zeros above the leading one.
  // ctz: the set bits of m are exactly the zeros below the trailing one.
  function automatic logic [DATA_WIDTH-1:0] f_mask(input logic [1:0]            op,
                                                   input logic [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] y;
    y = x;
    for (int k = 0; k < LOGW; k++) y = y | (y >> (1 << k));
    case (op)
      OP_CPOP: f_mask = x;
      OP_CLZ:  f_mask = ~y;
      OP_CTZ:  f_mask = ~x & (x - DATA_WIDTH'(1));
      default: f_mask = '0;
    endcase
  endfunction

  // Tree-halving adder: each level sums adjacent pairs of the level below.
  function automatic logic [CW-1:0] f_popcount(input logic [DATA_WIDTH-1:0] v);
    logic [CW-1:0] lvl [DATA_WIDTH];
    for (int j = 0; j < DATA_WIDTH; j++) lvl[j] = CW'(v[j]);
    for (int k = 0; k < LOGW; k++)
      for (int j = 0; j < (DATA_WIDTH >> (k + 1)); j++)
        lvl[j] = lvl[2*j] + lvl[2*j+1];
    return lvl[0];
  endfunction

  // Handshake: a beat moves on valid & ready at the rising edge; out_valid only
  // drops after a transfer (or flush/reset), and out_data/out_tag hold while stalled.
  assign w_adv     = !r_s2_valid || out_ready;
  assign w_s2_load = w_adv && r_s1_valid;
  assign in_ready  = !flush && (!r_s1_valid || w_adv);

  assign w_mask  = f_mask(in_op, in_data);
  assign w_count = f_popcount(r_s1_mask);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mask  <= '0;
      r_s1_tag   <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mask <= w_mask;
        r_s1_tag  <= in_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_tag  <= '0;
    end else if (flush) begin
      r_s2_valid <= 1'b0;
    end else if (w_adv) begin
      r_s2_valid <= r_s1_valid;
      if (w_s2_load) begin
        r_out_data <= DATA_WIDTH'(w_count);
        r_out_tag  <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_out_data;
  assign out_tag   = r_out_tag;
  assign busy      = r_s1_valid || r_s2_valid;

`ifdef BITCNT_PERF_EN
  logic [31:0] r_perf_count;

  // A result handed over in the flush cycle still counts as delivered.
  always_ff @(posedge clk) begin
    if (!rst_n) r_perf_count <= '0;
    else if (r_s2_valid && out_ready) r_perf_count <= r_perf_count + 32'd1;
  end

  assign perf_count = r_perf_count;
`endif

endmodule

// File: doc/bitcnt_unit.md
# bitcnt_unit

Pipelined bit-count execution unit for the Zbb `cpop`/`clz`/`ctz` instructions. It conditions the operand so that all three operations reduce to a population count, then registers the count and returns it to writeback over a valid/ready handshake. It sits between the execute-stage operand mux and the writeback arbiter.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width. Must be a power of two, 8 to 64.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `flush`  in  1: synchronous pipeline kill.
- `in_valid`  in  1: operand offered.
- `in_ready`  out  1: unit accepts this cycle.
- `in_op`  in  2: 00 `cpop`, 01 `clz`, 10 `ctz`, 11 reserved.
- `in_data`  in  DATA_WIDTH: rs1 value.
- `in_tag`  in  5: destination register index, passed through unchanged.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: writeback consumes.
- `out_data`  out  DATA_WIDTH: count, zero-extended.
- `out_tag`  out  5: tag of `out_data`.
- `busy`  out  1: `s1_valid | s2_valid`.

## Operation
- Stage S1 (conditioning) registers the mask vector `m`, the tag, and `s1_valid`:
  - `cpop`: m = x.
  - `clz`: m = ~(x | x>>1 | x>>2 | … | x>>(DATA_WIDTH/2)), a log-depth prefix-OR from the MSB.
  - `ctz`: m = ~x & (x − 1), modulo 2^DATA_WIDTH.
  - reserved: m = 0.
- Stage S2 (count) registers `out_data` = popcount(m) using a tree-halving adder network, plus the tag and `s2_valid`.
- Arithmetic rules:
  - Count range is 0..DATA_WIDTH; upper result bits are zero.
  - clz(0) = ctz(0) = DATA_WIDTH.
  - Reserved op returns 0.
- Handshake:
  - Transfer occurs on `valid & ready`.
  - S2 advances when `!s2_valid | out_ready`.
  - S1 advances into S2 under the same condition.
  - `in_ready = !s1_valid | (!s2_valid | out_ready)`, a combinational path from `out_ready`.
  - `out_valid` never drops without a transfer.
  - `out_data` and `out_tag` hold stable while `out_valid & !out_ready`.
- `flush`:
  - Clears `s1_valid` and `s2_valid` next edge.
  - `in_ready` is forced 0 in the flush cycle, so nothing is accepted.
  - A transfer handshaked on the output in the flush cycle is still counted as delivered.
- Reset (`rst_n` = 0 at an edge):
  - `s1_valid` = `s2_valid` = 0, `out_data` = 0, `out_tag` = 0.
  - Therefore `out_valid` = 0 and `busy` = 0.
  - `in_ready` = 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight ops.

## Timing
- Latency: accept at edge N gives `out_valid` high after edge N+1, so the result can be consumed at edge N+2.
- Throughput: one op per cycle while `out_ready` = 1.
- Back-pressure:
  - With `out_ready` = 0, both stages fill.
  - `in_ready` falls only when `s1_valid & s2_valid & !out_ready`.
  - When `out_ready` rises, S2 drains and S1 moves up on the same edge.
- Simultaneous flush and reset: reset wins; outcome is identical.
- Critical path: S2 adder tree. The S1 prefix-OR and subtract must not be merged into S2.

## Configuration
- `BITCNT_PERF_EN`:
  - Defined: adds output `perf_count` (32 bits), reset 0.
  - Increments by 1 on every output transfer (`out_valid & out_ready`), including one coinciding with `flush`.
  - Wraps from 0xFFFFFFFF to 0.
  - Not defined: port and counter are absent; behaviour is otherwise identical.

## Test plan
- Reset then single ops (`out_ready` = 1):
  - `cpop` 0xF0F0_0001 → 9.
  - `clz` 0x0008_0000 → 12.
  - `ctz` 0x0008_0000 → 19.
  - Each with `out_valid` two cycles after accept.
- Zero operand:
  - `clz` 0 → 32; `ctz` 0 → 32; `cpop` 0 → 0.
  - `cpop` 0xFFFF_FFFF → 32; reserved op on 0x1234 → 0.
- Streaming: 16 back-to-back random ops with tags 0..15 and `out_ready` = 1 → results in order, one per cycle, each matching a software model.
- Back-pressure:
  - Hold `out_ready` = 0 for 5 cycles while offering 3 ops → `in_ready` drops after 2 accepts.
  - `out_data`/`out_tag` stay stable until `out_ready` rises.
  - Order and values are preserved.
- Flush with both stages full → `out_valid` = 0 next cycle, `in_ready` = 1, no stale result is ever emitted.
- Assert `rst_n` = 0 mid-stream → all outputs zero next cycle; a new op after release completes normally. With `BITCNT_PERF_EN`, `perf_count` equals the number of completed transfers (e.g. 16 after the streaming test) and reads 0 after reset.
